// File: rtl/pipeline_hazard_controller.sv
// Hazard detection and forwarding-select generation for the 5-stage MIPS pipeline.
// Shadows the destination registers of the instructions in EX and MEM so that
// stall and forwarding decisions are made in ID from the ID fields alone.
module pipeline_hazard_controller #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic [4:0]             id_dest,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   id_cmp_reads,
  input  logic                   id_redirect,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic                   stall_sel,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   ifid_flush,
  output logic [STALL_CNT_W-1:0] stall_count
);

  // Operand source selects seen by the EX-stage multiplexers.
  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef struct packed {
    logic [4:0] dest;
    logic       reg_write;
    logic       mem_read;
  } shadow_t;

  shadow_t                r_exs;
  shadow_t                r_mems;
  logic [1:0]             r_fwd_a;
  logic [1:0]             r_fwd_b;
  logic [STALL_CNT_W-1:0] r_stall_count;

  logic       w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt;
  logic       w_load_use;
  logic       w_cmp_hazard;
  logic       w_stall;
  logic [1:0] w_fwd_a_next;
  logic [1:0] w_fwd_b_next;
  shadow_t    w_exs_next;

  // A producer matches only when it writes a real register the ID instruction reads.
  function automatic logic reg_match(input shadow_t e, input logic [4:0] r, input logic used);
    return used && e.reg_write && (e.dest != 5'd0) && (e.dest == r);
  endfunction

  // Hazard detection, next forwarding selects and next EX shadow entry.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_ex_rs      = reg_match(r_exs,  id_rs, id_uses_rs);
    w_ex_rt      = reg_match(r_exs,  id_rt, id_uses_rt);
    w_mem_rs     = reg_match(r_mems, id_rs, id_uses_rs);
    w_mem_rt     = reg_match(r_mems, id_rt, id_uses_rt);
    w_load_use   = 1'b0;
    w_cmp_hazard = 1'b0;
    w_fwd_a_next = FWD_RF;
    w_fwd_b_next = FWD_RF;
    w_exs_next   = '0;

    w_load_use = r_exs.mem_read && (w_ex_rs || w_ex_rt);
    // Branch/jr operands are needed in ID, so any EX producer or a load still in MEM stalls.
    w_cmp_hazard = id_cmp_reads &&
                   (w_ex_rs || w_ex_rt || (r_mems.mem_read && (w_mem_rs || w_mem_rt)));
    w_stall = w_load_use || w_cmp_hazard;

    // EX producer is the youngest, so it wins over MEM; a bubble never forwards.
    if (!w_stall) begin
      if (w_ex_rs)       w_fwd_a_next = FWD_EXMEM;
      else if (w_mem_rs) w_fwd_a_next = FWD_MEMWB;
      if (w_ex_rt)       w_fwd_b_next = FWD_EXMEM;
      else if (w_mem_rt) w_fwd_b_next = FWD_MEMWB;
      w_exs_next = '{dest: id_dest, reg_write: id_reg_write, mem_read: id_mem_read};
    end
  end

  // Shadow pipeline advance, registered forwarding selects and saturating stall counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_exs         <= '0;
      r_mems        <= '0;
      r_fwd_a       <= FWD_RF;
      r_fwd_b       <= FWD_RF;
      r_stall_count <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so MEMs takes the old EXs.
      r_exs   <= w_exs_next;
      r_mems  <= r_exs;
      r_fwd_a <= w_fwd_a_next;
      r_fwd_b <= w_fwd_b_next;
      if (w_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + STALL_CNT_W'(1);
      end
    end
  end

  assign fwd_a       = r_fwd_a;
  assign fwd_b       = r_fwd_b;
  assign stall_sel   = w_stall;
  assign pc_write    = ~w_stall;
  assign ifid_write  = ~w_stall;
  assign ifid_flush  = id_redirect & ~w_stall;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: a history-based reference model
// predicts every cycle's outputs; a separate monitor compares them against the DUT.
module tb_pipeline_hazard_controller;

  localparam int BIG_W   = 16;
  localparam int SMALL_W = 2;
  localparam int BIG_MAX   = (1 << BIG_W) - 1;
  localparam int SMALL_MAX = (1 << SMALL_W) - 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic       id_uses_rs = 0, id_uses_rt = 0, id_reg_write = 0, id_mem_read = 0;
  logic       id_cmp_reads = 0, id_redirect = 0;

  logic [1:0]         fwd_a, fwd_b;
  logic               stall_sel, pc_write, ifid_write, ifid_flush;
  logic [BIG_W-1:0]   stall_count;
  logic [1:0]         s_fwd_a, s_fwd_b;
  logic               s_stall_sel, s_pc_write, s_ifid_write, s_ifid_flush;
  logic [SMALL_W-1:0] s_stall_count;

  pipeline_hazard_controller #(.STALL_CNT_W(BIG_W)) dut (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_cmp_reads(id_cmp_reads), .id_redirect(id_redirect),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_sel(stall_sel), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .stall_count(stall_count)
  );

  pipeline_hazard_controller #(.STALL_CNT_W(SMALL_W)) dut_small (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_cmp_reads(id_cmp_reads), .id_redirect(id_redirect),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_sel(s_stall_sel), .pc_write(s_pc_write),
    .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush), .stall_count(s_stall_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0] dest;
    logic       rw;
    logic       mr;
  } instr_t;

  typedef struct {
    bit       stall;
    bit       flush;
    int       fa;
    int       fb;
    int       cnt_big;
    int       cnt_small;
  } exp_t;

  instr_t hist[$];   // hist[0] = instruction now in EX, hist[1] = now in MEM
  int     m_fa, m_fb, m_next_fa, m_next_fb, m_cnt;
  bit     m_stall;

  exp_t exp_q[$];
  event push_ev;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic bit writes(input instr_t p, input logic [4:0] r, input bit used);
    return used && p.rw && (r != 5'd0) && (p.dest == r);
  endfunction

  // Distance back to the youngest in-flight writer of r: 1 = EX, 2 = MEM, 0 = none.
  function automatic int producer_age(input logic [4:0] r, input bit used);
    if (writes(hist[0], r, used)) return 1;
    if (writes(hist[1], r, used)) return 2;
    return 0;
  endfunction

  task automatic model_clear();
    hist.delete();
    hist.push_back('0);
    hist.push_back('0);
    m_fa = 0; m_fb = 0; m_cnt = 0; m_stall = 0;
  endtask

  // Predict this cycle's outputs from the model and queue them for the monitor.
  task automatic push_expect();
    exp_t e;
    bit   lu, ch;
    lu = hist[0].mr && (producer_age(id_rs, id_uses_rs) == 1 || producer_age(id_rt, id_uses_rt) == 1);
    ch = id_cmp_reads &&
         (producer_age(id_rs, id_uses_rs) == 1 || producer_age(id_rt, id_uses_rt) == 1 ||
          (hist[1].mr && (writes(hist[1], id_rs, id_uses_rs) || writes(hist[1], id_rt, id_uses_rt))));
    m_stall   = lu || ch;
    m_next_fa = m_stall ? 0 : producer_age(id_rs, id_uses_rs);
    m_next_fb = m_stall ? 0 : producer_age(id_rt, id_uses_rt);
    e.stall     = m_stall;
    e.flush     = id_redirect && !m_stall;
    e.fa        = m_fa;
    e.fb        = m_fb;
    e.cnt_big   = (m_cnt > BIG_MAX)   ? BIG_MAX   : m_cnt;
    e.cnt_small = (m_cnt > SMALL_MAX) ? SMALL_MAX : m_cnt;
    exp_q.push_back(e);
    -> push_ev;
  endtask

  task automatic apply(input logic [4:0] rs, input logic [4:0] rt, input bit urs, input bit urt,
                       input logic [4:0] dest, input bit rw, input bit mr,
                       input bit cmp, input bit redir, input bit rstn);
    #1;
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_dest = dest; id_reg_write = rw; id_mem_read = mr;
    id_cmp_reads = cmp; id_redirect = redir; reset_n = rstn;
    if (!rstn) model_clear();
    push_expect();
  endtask

  // Model state at the rising edge.
  task automatic advance();
    if (!reset_n) begin
      model_clear();
    end else begin
      if (m_stall) m_cnt++;
      hist.push_front(m_stall ? instr_t'('0) : instr_t'{id_dest, id_reg_write, id_mem_read});
      void'(hist.pop_back());
      m_fa = m_next_fa;
      m_fb = m_next_fb;
    end
  endtask

  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input bit urs, input bit urt,
                      input logic [4:0] dest, input bit rw, input bit mr,
                      input bit cmp, input bit redir, input bit rstn);
    apply(rs, rt, urs, urt, dest, rw, mr, cmp, redir, rstn);
    @(posedge clk);
    advance();
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(push_ev);
      #2;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("stall_sel",        32'(stall_sel),     32'(e.stall));
        check("pc_write",         32'(pc_write),      32'(!e.stall));
        check("ifid_write",       32'(ifid_write),    32'(!e.stall));
        check("ifid_flush",       32'(ifid_flush),    32'(e.flush));
        check("fwd_a",            32'(fwd_a),         32'(e.fa));
        check("fwd_b",            32'(fwd_b),         32'(e.fb));
        check("stall_count",      32'(stall_count),   32'(e.cnt_big));
        check("stall_count_sat",  32'(s_stall_count), 32'(e.cnt_small));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    model_clear();
    @(posedge clk);
    advance();

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++)
      step($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1), 0);

    // Forwarding chain: add $3; sub rs=$3; or rt=$3.
    step(1, 2, 1, 1, 3, 1, 0, 0, 0, 1);
    step(3, 4, 1, 1, 8, 1, 0, 0, 0, 1);
    step(5, 3, 1, 1, 9, 1, 0, 0, 0, 1);
    nop(); nop();

    // Load-use: lw $5; add rs=$5 (re-presented after the bubble).
    step(1, 5, 1, 0, 5, 1, 1, 0, 0, 1);
    step(5, 2, 1, 1, 6, 1, 0, 0, 0, 1);
    step(5, 2, 1, 1, 6, 1, 0, 0, 0, 1);
    nop(); nop();

    // Load then beq with redirect: two bubbles, flush on the third cycle.
    step(1, 7, 1, 0, 7, 1, 1, 0, 0, 1);
    repeat (3) step(7, 0, 1, 1, 0, 0, 0, 1, 1, 1);
    nop(); nop();

    // Writer to $0 then reader of $0; then $4 written twice and read.
    step(1, 2, 1, 1, 0, 1, 0, 0, 0, 1);
    step(0, 0, 1, 1, 10, 1, 0, 1, 0, 1);
    step(1, 2, 1, 1, 4, 1, 0, 0, 0, 1);
    step(1, 2, 1, 1, 4, 1, 0, 0, 0, 1);
    step(4, 4, 1, 1, 11, 1, 0, 0, 0, 1);
    nop(); nop();

    // Five load-use pairs push the narrow counter into saturation.
    for (int i = 0; i < 5; i++) begin
      step(1, 5, 1, 0, 5, 1, 1, 0, 0, 1);
      step(5, 2, 1, 1, 6, 1, 0, 0, 0, 1);
      step(5, 2, 1, 1, 6, 1, 0, 0, 0, 1);
    end
    nop();

    // Reset asserted in the middle of a stall cycle.
    step(1, 9, 1, 0, 9, 1, 1, 0, 0, 1);
    apply(9, 2, 1, 1, 12, 1, 0, 0, 1, 1);
    #5;
    reset_n = 1'b0;
    model_clear();
    push_expect();
    @(posedge clk);
    advance();
    step(9, 2, 1, 1, 12, 1, 0, 0, 1, 0);
    step(9, 2, 1, 1, 12, 1, 0, 0, 1, 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bit rw, mr;
      rw = $urandom_range(0, 3) != 0;
      mr = rw && ($urandom_range(0, 2) == 0);
      step($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 7), rw, mr,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 199) != 0);
    end

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central hazard and forwarding controller for the 5-stage MIPS pipeline. It generates the select lines that drive the datapath multiplexers: the ALU operand forwarding selects, the ID-stage stall/bubble select, the PC and IF/ID write enables, and the IF/ID flush for taken control transfers. It keeps its own shadow of the destination registers in flight in EX and MEM, so each forwarding decision is made one cycle early in ID and registered into EX.

## Interface
Parameters:
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_uses_rs  input  1  ID instruction reads rs (ALU operand or compare).
- id_uses_rt  input  1  ID instruction reads rt.
- id_dest  input  5  destination register of the ID instruction, already resolved: rt, rd, or 31 for jal.
- id_reg_write  input  1  ID instruction writes the register file.
- id_mem_read  input  1  ID instruction is a load.
- id_cmp_reads  input  1  ID instruction compares or reads registers in ID (beq/bne/jr).
- id_redirect  input  1  ID resolved a taken branch, j, jal, or jr this cycle.
- fwd_a  output  2  EX operand A select: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result.
- fwd_b  output  2  EX operand B select, same encoding as fwd_a.
- stall_sel  output  1  1 = zero the RegWrite/MemWrite controls entering ID/EX (bubble).
- pc_write  output  1  0 holds the PC.
- ifid_write  output  1  0 holds the IF/ID register.
- ifid_flush  output  1  1 = load IF/ID with a nop.
- stall_count  output  STALL_CNT_W  number of bubble cycles inserted; saturates.

## Operation
- The block holds shadow entries EXs and MEMs. Each entry contains {dest[4:0], reg_write, mem_read}.
- Every clock, EXs is loaded from the ID inputs, or from all zeros when stall_sel=1. MEMs is loaded from EXs. There is no enable; the pipeline always advances.
- A register match requires a nonzero register number, the entry's reg_write=1, and the corresponding id_uses_* bit set. Register $0 never matches.
- Load-use hazard: EXs.mem_read=1 and EXs matches rs or rt.
- Compare hazard (only when id_cmp_reads=1) is any of:
  - EXs matches, whether it is an ALU op or a load.
  - MEMs.mem_read=1 and MEMs matches.
- stall = load-use OR compare hazard. This is a combinational function of the current inputs and the shadow state.
- Outputs driven by stall:
  - stall_sel = stall.
  - pc_write = ifid_write = ~stall.
- ifid_flush = id_redirect & ~stall. A redirect is never honoured while the instruction is stalled.
- Forwarding is computed in ID and registered into fwd_a/fwd_b at the clock edge:
  - EXs match → 1.
  - else MEMs match → 2.
  - else 0.
  - EX has priority over MEM.
  - If stall=1, the registered value is 0, so a bubble never forwards.
- A load followed by a compare sequences itself by re-evaluation: 2 bubbles while the load is in EX and then in MEM. No explicit counter state is used.
- stall_count increments on every cycle in which stall=1 and holds at all-ones.

## Timing
- Reset, asynchronous while reset_n=0:
  - EXs, MEMs, fwd_a, fwd_b, and stall_count are cleared to 0.
  - stall_sel=0, pc_write=1, ifid_write=1.
  - ifid_flush follows id_redirect, because no shadow entry can match.
- Reset asserted mid-stall clears the shadow state immediately. The stall drops in the same cycle, with no edge required.
- Latencies:
  - stall_sel, pc_write, ifid_write, and ifid_flush are combinational (0 cycles) from the inputs and shadow state.
  - fwd_a and fwd_b are registered: 1 cycle. They are valid for the whole EX cycle of the instruction they were computed for.
- Stall counts:
  - Load-use: exactly 1 bubble.
  - Compare after ALU producer: 1 bubble.
  - Compare immediately after a load: 2 bubbles.
  - Compare one instruction after a load: 1 bubble.
- Simultaneous id_redirect and stall: the stall wins. The flush fires in the first non-stalled cycle, provided id_redirect is still asserted.
- If EXs and MEMs both match the same register, fwd selects 1, the youngest producer.
- stall_count wraps never; it stays at 2^STALL_CNT_W−1.

## Test plan
- Reset: hold reset_n=0 with random inputs → fwd_a=fwd_b=0, stall_sel=0, pc_write=1, stall_count=0. Release reset → no stall on the first instruction.
- Forwarding chain: add $3 (dest 3), then sub reading rs=3, then or reading rt=3 → the sub in EX sees fwd_a=1. One cycle later the or in EX sees fwd_b=2. No stalls.
- Load-use: lw $5, then add with rs=5 → exactly 1 cycle of stall_sel=1 and pc_write=0. The add's EX cycle has fwd_a=2. stall_count=1.
- Load then beq: lw $7, then beq reading $7 with id_redirect=1 → 2 stall cycles with ifid_flush=0. ifid_flush=1 appears on the 3rd cycle. stall_count=2.
- $0 and priority: a writer to $0 followed by a reader of $0 → fwd=0, no stall. Writers to $4 in both MEMs and EXs → fwd_a=1.
- Saturation and mid-stall reset: with STALL_CNT_W=2, 5 load-use pairs → stall_count=3. Assert reset_n=0 during a stall → stall_sel drops combinationally and stall_count=0.
